// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling, glitch/framing checks and a one-byte holding register
module uart_rx #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CPB  = CLK_HZ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_BIT  = CW'(CPB - 1);

    if (CPB < 4) begin : g_cpb_check
        $error("uart_rx: CLK_HZ/BAUD must be at least 4");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift, shift_n;
    logic          done, done_n, ferr_n;
    logic          sync1, s;

    // Both stages preset to 1 so reset never looks like a start edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            s     <= 1'b1;
        end else begin
            sync1 <= rx_i;
            s     <= sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            shift     <= shift_n;
            done      <= done_n;
            frame_err <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        shift_n = shift;
        done_n  = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!s) state_n = START;
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_BIT) begin
                    cnt_n   = '0;
                    shift_n = {s, shift[7:1]};
                    idx_n   = idx + 3'd1;
                    if (idx == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == CNT_BIT) begin
                    cnt_n = '0;
                    if (s) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = BRK;
                    end
                end
            end
            BRK: begin
                // A held-low line must return high before another start is accepted
                cnt_n = '0;
                if (s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx at CPB=10
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_i = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    int n_pass  = 0;
    int n_total = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    int fv;
    int f0;
    int o0;

    uart_rx #(.CLK_HZ(1000000), .BAUD(100000)) dut (
        .clk(clk), .rst(rst), .rx_i(rx_i),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .busy(busy), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Drives one frame starting at a negedge; n counts rising edges since the start bit was driven.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int ready_at,
                              output int first_valid);
        int n = 0;
        first_valid = -1;
        for (int b = 0; b < 10; b++) begin
            rx_i = (b == 0) ? 1'b0 : (b == 9) ? stop : d[b-1];
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                n++;
                if (ready_at != 0) rx_ready = (n == ready_at);
                if (rx_valid && first_valid < 0) first_valid = n;
            end
        end
    endtask

    task automatic accept();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;

        repeat (200) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_rx_valid", rx_valid, 0);
        check("idle_pulses", ferr_cnt + ovr_cnt, 0);

        // start seen by the FSM at edge 3, so valid appears after edge 3+96
        send_frame(8'hA5, 1'b1, 0, fv);
        check("a5_valid_latency", fv, 99);
        check("a5_data", rx_data, 8'hA5);
        repeat (50) @(negedge clk);
        check("a5_hold_data", rx_data, 8'hA5);
        check("a5_hold_valid", rx_valid, 1);
        accept();
        check("a5_accept_clears", rx_valid, 0);

        f0 = ferr_cnt;
        rx_i = 1'b0;
        repeat (3) @(negedge clk);
        check("glitch_busy_start", busy, 1);
        rx_i = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_busy_idle", busy, 0);
        check("glitch_no_valid", rx_valid, 0);
        check("glitch_no_ferr", ferr_cnt - f0, 0);

        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 0, fv);
        repeat (30) @(negedge clk);
        check("ferr_busy_held", busy, 1);
        check("ferr_one_pulse", ferr_cnt - f0, 1);
        check("ferr_no_valid", rx_valid, 0);
        rx_i = 1'b1;
        repeat (5) @(negedge clk);
        check("ferr_busy_release", busy, 0);
        send_frame(8'h55, 1'b1, 0, fv);
        check("after_ferr_valid", rx_valid, 1);
        check("after_ferr_data", rx_data, 8'h55);
        accept();

        o0 = ovr_cnt;
        send_frame(8'h11, 1'b1, 0, fv);
        send_frame(8'h22, 1'b1, 0, fv);
        repeat (5) @(negedge clk);
        check("ovr_data_kept", rx_data, 8'h11);
        check("ovr_valid", rx_valid, 1);
        check("ovr_one_pulse", ovr_cnt - o0, 1);
        accept();
        check("ovr_accept_clears", rx_valid, 0);

        o0 = ovr_cnt;
        send_frame(8'h11, 1'b1, 0, fv);
        send_frame(8'h22, 1'b1, 98, fv);
        repeat (5) @(negedge clk);
        check("simul_data", rx_data, 8'h22);
        check("simul_valid", rx_valid, 1);
        check("simul_no_overrun", ovr_cnt - o0, 0);

        // 0xF0: bits 0..3 low, reset lands mid bit 4 while rx_valid still holds 0x22
        rx_i = 1'b0;
        repeat (50) @(negedge clk);
        rx_i = 1'b1;
        repeat (5) @(negedge clk);
        check("mid_busy_before", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", rx_valid, 0);
        check("mid_rst_data", rx_data, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("mid_no_output", rx_valid, 0);
        check("mid_idle", busy, 0);
        send_frame(8'h81, 1'b1, 0, fv);
        check("post_rst_latency", fv, 99);
        check("post_rst_data", rx_data, 8'h81);
        check("post_rst_valid", rx_valid, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
